instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC value loaded at reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  64  byte address of requested instruction (= pc).
REQ-006 imem_ack  input  1  memory response valid; qualifies imem_rdata.
REQ-007 imem_rdata  input  32  instruction word returned by memory.
REQ-008 stall  input  1  downstream hold; current instruction is not retired while high.
REQ-009 br  input  1  branch flag from control decoder for the current instruction.
REQ-010 zero  input  1  ALU zero flag for the current instruction.
REQ-011 br_offset  input  64  sign-extended word offset of the branch target.
REQ-012 instr_valid  output  1  instr/opcode/pc describe a live instruction.
REQ-013 instr  output  32  latched instruction word.
REQ-014 opcode  output  11  instr[31:21], feeds the control decoder.
REQ-015 pc  output  64  address of the current instruction.

Function
REQ-016 FSM states SHALL be FETCH and EXEC only.
REQ-017 FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ack=1.
REQ-018 FETCH with imem_ack=1: instr latched from imem_rdata; next state EXEC; imem_req=0 in EXEC.
REQ-019 Latency: ack in cycle N gives instr_valid=1 in cycle N+1.
REQ-020 EXEC: instr_valid=1; instr/opcode/pc held constant while stall=1.
REQ-021 EXEC with stall=0 retires the instruction: pc <= (br & zero) ? pc + (br_offset << 2) : pc + 4; next state FETCH.
REQ-022 br and zero SHALL be sampled only in the retire cycle; values at other times are ignored.
REQ-023 PC arithmetic is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0 with no error.
REQ-024 Negative br_offset (two's complement) SHALL give a backward target.
REQ-025 imem_ack in EXEC SHALL be ignored, with no state or data change.
REQ-026 instr_valid=0 in FETCH; instr keeps its last value but is not valid.

Reset
REQ-027 rst_n=0 asynchronously forces: state=FETCH, pc=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0.
REQ-028 imem_req SHALL first assert in the first clk edge after rst_n deasserts.
REQ-029 Reset mid-FETCH abandons the outstanding request; a late ack arriving during reset is dropped.

Configuration
REQ-030 Macro IFETCH_RETIRE_CNT_EN defined: adds output retire_cnt (32 bits), reset to 0, incremented on each retire cycle, wrapping at 2^32.
REQ-031 Macro undefined: retire_cnt port and its counter are absent; all other behaviour is identical.

Structure
REQ-032 Shared package legv8_pkg SHALL hold INSTR_W=32, OPCODE_W=11, OPCODE_MSB=31, OPCODE_LSB=21, INSTR_BYTES=4, and the fetch state enum.
REQ-033 Next-PC computation SHALL live in a combinational sub-module ifetch_pc_next (inputs pc, br, zero, br_offset; output pc_next).

Verification
REQ-034 Reset with RESET_PC=0x100 and ack after 3 wait cycles, rdata=0xF84003E1 -> imem_addr=0x100 held 4 cycles; next cycle instr_valid=1, opcode=11'b11111000010.
REQ-035 Retire with br=1, zero=1, br_offset=-2 at pc=0x200 -> next imem_addr=0x1F8.
REQ-036 Retire with br=1, zero=0 at pc=0x200 -> next imem_addr=0x204.
REQ-037 stall=1 for 5 cycles in EXEC with br/zero toggling -> outputs frozen, imem_req=0; the single retire happens on stall release.
REQ-038 rst_n pulsed low mid-FETCH at pc=0x40 -> pc=RESET_PC immediately; a stray ack during reset has no effect.
REQ-039 pc=0xFFFF_FFFF_FFFF_FFFC, non-branch retire -> imem_addr=0x0; with IFETCH_RETIRE_CNT_EN, retire_cnt increments by 1.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch-stage constants, state encoding and helpers.
package legv8_pkg;

  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned OPCODE_W    = 11;
  localparam int unsigned OPCODE_MSB  = 31;
  localparam int unsigned OPCODE_LSB  = 21;
  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned PC_W        = 64;

  // Fetch state encoding, kept as plain constants for legacy tool flows.
  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t FETCH = 1'b0;
  localparam fetch_state_t EXEC  = 1'b1;

  // Opcode field used by the control decoder.
  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/ifetch_pc_next.sv
// Next-PC adder: taken branch adds the word offset, otherwise step one instruction.
module ifetch_pc_next
  import legv8_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic            br,
  input  logic            zero,
  input  logic [PC_W-1:0] br_offset,
  output logic [PC_W-1:0] pc_next
);

  // Modulo-2^64 arithmetic; the top two offset bits fall off when scaling to bytes.
  always_comb begin
    if (br && zero) begin
      pc_next = pc + (br_offset << 2);
    end else begin
      pc_next = pc + PC_W'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Two-state instruction fetch unit: FETCH issues a memory read at pc and latches the
// returned word, EXEC presents it until the downstream stage retires it.
// Optional feature: define IFETCH_RETIRE_CNT_EN to add the 32-bit retire_cnt output.
module instr_fetch
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                br,
  input  logic                zero,
  input  logic [PC_W-1:0]     br_offset,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [PC_W-1:0]     pc
`ifdef IFETCH_RETIRE_CNT_EN
  ,
  output logic [31:0]         retire_cnt
`endif
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               req_q, req_d;
  logic [PC_W-1:0]    pc_next;
  logic               accept;
  logic               retire;

  ifetch_pc_next u_pc_next (
    .pc        (pc_q),
    .br        (br),
    .zero      (zero),
    .br_offset (br_offset),
    .pc_next   (pc_next)
  );

  // Ack only counts while a request is actually on the bus, so a stray ack in the
  // first cycle after reset (request not yet raised) or in EXEC is dropped.
  assign accept = (state_q == FETCH) && req_q && imem_ack;
  assign retire = (state_q == EXEC) && !stall;

  // Next-state, PC and instruction-latch logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (state_q == FETCH) begin
      if (accept) begin
        instr_d = imem_rdata;
        state_d = EXEC;
      end
    end else begin
      if (retire) begin
        pc_d    = pc_next;
        state_d = FETCH;
      end
    end
    // Registered request: low during reset, rises on the first edge afterwards.
    req_d = (state_d == FETCH);
  end

  // Fetch-stage state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == EXEC);
  assign instr       = instr_q;
  assign opcode      = get_opcode(instr_q);
  assign pc          = pc_q;

`ifdef IFETCH_RETIRE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Retired-instruction counter, wraps naturally at 2^32.
  always_comb begin
    cnt_d = cnt_q + (retire ? 32'd1 : 32'd0);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of fetched words.
module tb_instr_fetch;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic        zero = 1'b0;
  logic [63:0] br_offset = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic [63:0] pc;
`ifdef IFETCH_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  instr_fetch #(
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .br          (br),
    .zero        (zero),
    .br_offset   (br_offset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .pc          (pc)
`ifdef IFETCH_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic [63:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] m_pc   = RST_PC;
  logic [31:0] m_cnt  = '0;
  logic [31:0] cur_instr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef IFETCH_RETIRE_CNT_EN
    chk(tag, {32'h0, retire_cnt}, {32'h0, m_cnt});
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  // Compare the presented instruction against the oldest scoreboard entry.
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      cur_instr = e.word;
      chk("valid_exec", {63'h0, instr_valid}, 64'h1);
      chk("instr", {32'h0, instr}, {32'h0, e.word});
      chk("opcode", {53'h0, opcode}, {53'h0, e.word[31:21]});
      chk("pc_exec", pc, e.addr);
      chk("req_exec", {63'h0, imem_req}, 64'h0);
    end
  endtask

  // Called at a negedge in FETCH with the request already raised.
  task automatic fetch(input logic [31:0] rd, input int waits);
    for (int i = 0; i < waits; i++) begin
      chk("req_wait", {63'h0, imem_req}, 64'h1);
      chk("addr_wait", imem_addr, m_pc);
      chk("valid_fetch", {63'h0, instr_valid}, 64'h0);
      @(negedge clk);
    end
    chk("req_ack", {63'h0, imem_req}, 64'h1);
    chk("addr_ack", imem_addr, m_pc);
    imem_ack   = 1'b1;
    imem_rdata = rd;
    sb.push_back('{word: rd, addr: m_pc});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check_out();
  endtask

  // Called at a negedge in EXEC; stalls, then retires with the given branch inputs.
  task automatic retire(input logic b, input logic z, input logic [63:0] off,
                        input int stall_n, input logic [63:0] exp_next);
    logic [63:0] pc_hold;
    pc_hold = m_pc;
    for (int i = 0; i < stall_n; i++) begin
      stall      = 1'b1;
      br         = i[0];
      zero       = 1'b1;
      br_offset  = 64'h10;
      imem_ack   = ~i[0];
      imem_rdata = $urandom;
      @(negedge clk);
      chk("stall_valid", {63'h0, instr_valid}, 64'h1);
      chk("stall_instr", {32'h0, instr}, {32'h0, cur_instr});
      chk("stall_pc", pc, pc_hold);
      chk("stall_req", {63'h0, imem_req}, 64'h0);
      chk_cnt("stall_cnt");
    end
    stall     = 1'b0;
    imem_ack  = 1'b0;
    br        = b;
    zero      = z;
    br_offset = off;
    @(negedge clk);
    m_pc  = exp_next;
    m_cnt = m_cnt + 32'd1;
    br    = 1'b0;
    zero  = 1'b0;
    chk("next_addr", imem_addr, exp_next);
    chk("next_req", {63'h0, imem_req}, 64'h1);
    chk("next_valid", {63'h0, instr_valid}, 64'h0);
    chk("instr_kept", {32'h0, instr}, {32'h0, cur_instr});
    chk_cnt("retire_cnt");
  endtask

  initial begin
    // Power-on reset held across edges.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_instr", {32'h0, instr}, 64'h0);
    chk_cnt("rst_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("req_before_edge", {63'h0, imem_req}, 64'h0);
    @(negedge clk);

    // Reset fetch: 3 wait cycles then ack.
    fetch(32'hF84003E1, 3);
    chk("opcode_const", {53'h0, opcode}, {53'h0, 11'b11111000010});
    retire(1'b1, 1'b1, 64'h40, 0, 64'h200);

    // Taken backward branch.
    fetch(32'h8B020020, 0);
    retire(1'b1, 1'b1, -64'sd2, 0, 64'h1F8);

    fetch(32'hB4000040, 1);
    retire(1'b1, 1'b1, 64'h2, 0, 64'h200);

    // Branch not taken.
    fetch(32'hCB030041, 0);
    retire(1'b1, 1'b0, 64'h7, 0, 64'h204);

    // Long stall with toggling br/zero and stray acks.
    fetch(32'h91001021, 2);
    retire(1'b0, 1'b1, 64'h3, 5, 64'h208);

    // Jump to 0x40, then reset mid-FETCH there.
    fetch(32'h17FFFF8E, 0);
    retire(1'b1, 1'b1, -64'sd114, 0, 64'h40);
    chk("addr_40", imem_addr, 64'h40);
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    #1;
    chk("mid_rst_pc", pc, RST_PC);
    chk("mid_rst_req", {63'h0, imem_req}, 64'h0);
    chk("mid_rst_valid", {63'h0, instr_valid}, 64'h0);
    chk("mid_rst_instr", {32'h0, instr}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    rst_n    = 1'b1;
    m_pc     = RST_PC;
    m_cnt    = '0;
    sb.delete();
    #1;
    chk("post_rst_req0", {63'h0, imem_req}, 64'h0);
    chk("post_rst_valid", {63'h0, instr_valid}, 64'h0);
    chk_cnt("post_rst_cnt");
    @(negedge clk);

    // Walk to the top of the address space, then wrap.
    fetch(32'h17FFFFBF, 0);
    retire(1'b1, 1'b1, -64'sd65, 0, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(32'hAA0103E0, 1);
    retire(1'b0, 1'b0, 64'h0, 0, 64'h0);
    fetch(32'hD503201F, 0);
    chk("pc_zero", pc, 64'h0);
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
